// File: rtl/riscv_pkg.sv
// ============================================================================
// Module      : riscv_pkg
// Description : Types and constants shared by the riscv_pipelined_processor
//               front end (fetch entry layout, NOP encoding, reset PC).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

  localparam int REG_WIDTH = 32;

  // Canonical NOP (addi x0, x0, 0); decode inserts it for bubbles.
  localparam logic [REG_WIDTH-1:0] INST_NOP = 32'h0000_0013;

  // Default PC loaded on reset.
  localparam logic [REG_WIDTH-1:0] RESET_PC = 32'h0000_0000;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [REG_WIDTH-1:0] pc;
    logic [REG_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage : riscv_pkg

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : Small synchronous FIFO of fetch entries. Flush empties the
//               queue and takes priority over a push on the same edge. The
//               head reads as zero while the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  fetch_entry_t           push_data_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int             PW     = $clog2(DEPTH);
  localparam logic [PW:0]    C_FULL = (PW+1)'(DEPTH);

  fetch_entry_t    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q,  count_d;
  logic            w_pop;
  logic            w_push;

  // A pop needs data; a push needs room, which a same-edge pop provides.
  assign w_pop  = pop_i  && (count_q != '0);
  assign w_push = push_i && ((count_q != C_FULL) || w_pop) && !flush_i;

  // Next pointer/occupancy state; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Register pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (w_push && !rst) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule : fetch_queue

`default_nettype wire

// File: rtl/fetch_stage.sv
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch front end. Owns the PC, issues word
//               addresses to a 1-cycle synchronous instruction memory under
//               a credit rule that keeps the prefetch queue from
//               overflowing, and restarts on redirects from execute.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
  parameter int                   REG_WIDTH  = 32,
  parameter int                   NUM_INST   = 128,
  parameter int                   FIFO_DEPTH = 4,
  parameter logic [REG_WIDTH-1:0] RESET_PC   = riscv_pkg::RESET_PC
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req,
  output logic [$clog2(NUM_INST)-1:0] imem_addr,
  input  logic [REG_WIDTH-1:0]        imem_rdata,
  input  logic                        redirect_valid,
  input  logic [REG_WIDTH-1:0]        redirect_pc,
  input  logic                        id_ready,
  output logic                        id_valid,
  output logic [REG_WIDTH-1:0]        id_inst,
  output logic [REG_WIDTH-1:0]        id_pc
);

  import riscv_pkg::*;

  localparam int AW = $clog2(NUM_INST);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [REG_WIDTH-1:0] pc_q,        pc_d;
  logic [REG_WIDTH-1:0] req_pc_q,    req_pc_d;
  logic                 epoch_q,     epoch_d;
  logic                 req_epoch_q, req_epoch_d;
  logic                 inflight_q,  inflight_d;

  logic [CW-1:0]        w_count;
  logic [CW:0]          w_used;
  logic                 w_push;
  logic                 w_pop;
  fetch_entry_t         w_head;
  fetch_entry_t         w_push_entry;
  logic                 w_unused_redirect_lsbs;

  // Target is forced word-aligned, so its low bits never matter.
  assign w_unused_redirect_lsbs = &{1'b0, redirect_pc[1:0]};

  // Queue slots already spoken for: stored entries plus the pending response.
  assign w_used    = {1'b0, w_count} + {{CW{1'b0}}, inflight_q};
  assign imem_req  = !rst && !redirect_valid && (w_used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc_q[AW+1:2];

  // A response is kept only if no redirect has happened since it was issued.
  assign w_push       = !rst && inflight_q && (req_epoch_q == epoch_q) && !redirect_valid;
  assign w_push_entry = '{pc: req_pc_q, inst: imem_rdata};
  assign w_pop        = id_valid && id_ready;

  fetch_queue #(
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (w_push),
    .push_data_i (w_push_entry),
    .pop_i       (w_pop),
    .flush_i     (redirect_valid),
    .head_o      (w_head),
    .count_o     (w_count)
  );

  assign id_valid = !rst && (w_count != '0);
  assign id_inst  = id_valid ? w_head.inst : '0;
  assign id_pc    = id_valid ? w_head.pc   : '0;

  // Next PC / epoch / in-flight tracking; a redirect overrides issue.
  always_comb begin
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    epoch_d     = epoch_q;
    req_epoch_d = req_epoch_q;
    inflight_d  = inflight_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[REG_WIDTH-1:2], 2'b00};
      epoch_d    = ~epoch_q;
      inflight_d = 1'b0;
    end else begin
      inflight_d = imem_req;
      if (imem_req) begin
        pc_d        = pc_q + REG_WIDTH'(4);
        req_pc_d    = pc_q;
        req_epoch_d = epoch_q;
      end
    end
  end

  // Fetch control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      epoch_q     <= 1'b0;
      req_epoch_q <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      epoch_q     <= epoch_d;
      req_epoch_q <= req_epoch_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule : fetch_stage

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage with a queue-based
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

  localparam int NUM_INST = 128;
  localparam int DEPTH    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_stage #(
    .REG_WIDTH  (32),
    .NUM_INST   (NUM_INST),
    .FIFO_DEPTH (DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, one cycle of read latency.
  logic [31:0] mem [NUM_INST];
  initial for (int i = 0; i < NUM_INST; i++) mem[i] = 32'(i + 100);
  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

  // Reference model: a PC, an optional outstanding fetch, a list of entries.
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  int          m_infl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_at(input logic [31:0] pc);
    return 32'(pc[8:2]) + 32'd100;
  endfunction

  // Advance the model across one clock edge using the inputs held before it.
  task automatic model_edge();
    bit can_issue;
    bit pop;
    if (rst) begin
      m_pc   = 32'h0;
      m_infl = 0;
      mq.delete();
    end else begin
      pop       = (mq.size() != 0) && id_ready;
      can_issue = !redirect_valid && ((mq.size() + m_infl) < DEPTH);
      if (redirect_valid) begin
        mq.delete();
        m_infl = 0;
        m_pc   = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_infl != 0) mq.push_back('{pc: m_ipc, inst: mem_at(m_ipc)});
        m_infl = can_issue ? 1 : 0;
        if (can_issue) begin
          m_ipc = m_pc;
          m_pc  = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    bit          ev;
    bit          er;
    logic [31:0] ep;
    logic [31:0] ei;
    ev = !rst && (mq.size() != 0);
    ep = ev ? mq[0].pc   : 32'h0;
    ei = ev ? mq[0].inst : 32'h0;
    er = !rst && !redirect_valid && ((mq.size() + m_infl) < DEPTH);
    check("id_valid", {31'b0, id_valid}, {31'b0, ev});
    check("id_pc",    id_pc,   ep);
    check("id_inst",  id_inst, ei);
    check("imem_req", {31'b0, imem_req}, {31'b0, er});
    if (er) check("imem_addr", {25'b0, imem_addr}, {25'b0, m_pc[8:2]});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  initial begin
    int pct;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
    m_pc = 32'h0; m_ipc = 32'h0; m_infl = 0;
    @(negedge clk);
    tick(); tick();

    // Reset release: issue in cycle 0, first entry in cycle 2, then streaming.
    check("lit_rst_valid", {31'b0, id_valid}, 32'd0);
    check("lit_rst_req",   {31'b0, imem_req}, 32'd0);
    rst = 1'b0; id_ready = 1'b1;
    #1 check("lit_c0_req", {31'b0, imem_req}, 32'd1);
    tick();
    check("lit_c1_valid", {31'b0, id_valid}, 32'd0);
    tick();
    check("lit_c2_valid", {31'b0, id_valid}, 32'd1);
    check("lit_c2_pc",    id_pc,   32'h0);
    check("lit_c2_inst",  id_inst, 32'd100);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("lit_stream_pc",   id_pc,   32'(4 * k));
      check("lit_stream_inst", id_inst, 32'(100 + k));
    end

    // Back-pressure: queue fills to four entries, issue stops, head holds.
    rst = 1'b1; tick(); rst = 1'b0; id_ready = 1'b0;
    repeat (10) tick();
    check("lit_full_req",  {31'b0, imem_req}, 32'd0);
    check("lit_full_inst", id_inst, 32'd100);
    id_ready = 1'b1;
    tick();
    check("lit_drain_pc", id_pc, 32'h4);
    repeat (6) tick();

    // Redirect with three queued and one in flight.
    rst = 1'b1; tick(); rst = 1'b0; id_ready = 1'b0;
    repeat (4) tick();
    check("lit_pre_req", {31'b0, imem_req}, 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    check("lit_rd_t1", {31'b0, id_valid}, 32'd0);
    redirect_valid = 1'b0; id_ready = 1'b1;
    tick();
    check("lit_rd_t2", {31'b0, id_valid}, 32'd0);
    tick();
    check("lit_rd_pc",   id_pc,   32'h40);
    check("lit_rd_inst", id_inst, 32'd116);

    // Misaligned target, then back-to-back redirects.
    redirect_valid = 1'b1; redirect_pc = 32'h43;
    tick(); redirect_valid = 1'b0; tick(); tick();
    check("lit_mis_pc", id_pc, 32'h40);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick(); redirect_pc = 32'h60;
    tick(); redirect_valid = 1'b0;
    tick();
    check("lit_b2b_t2", {31'b0, id_valid}, 32'd0);
    tick();
    check("lit_b2b_pc",   id_pc,   32'h60);
    check("lit_b2b_inst", id_inst, 32'd124);

    // Index wrap past the end of instruction memory.
    redirect_valid = 1'b1; redirect_pc = 32'h1F8;
    tick(); redirect_valid = 1'b0;
    check("lit_wrap_a126", {25'b0, imem_addr}, 32'd126);
    tick();
    check("lit_wrap_a127", {25'b0, imem_addr}, 32'd127);
    tick();
    check("lit_wrap_a0",   {25'b0, imem_addr}, 32'd0);
    check("lit_wrap_p1f8", id_pc, 32'h1F8);
    tick(); tick();
    check("lit_wrap_p200", id_pc,   32'h200);
    check("lit_wrap_i200", id_inst, 32'd100);

    // Reset pulse with a full queue.
    id_ready = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    #1 check("lit_midrst_valid", {31'b0, id_valid}, 32'd0);
    tick(); rst = 1'b0; id_ready = 1'b1;
    tick();
    check("lit_post_c1", {31'b0, id_valid}, 32'd0);
    tick();
    check("lit_post_pc",   id_pc,   32'h0);
    check("lit_post_inst", id_inst, 32'd100);

    // Random traffic.
    pct = 100;
    for (int c = 0; c < 4000; c++) begin
      if (c % 100 == 0) begin
        case ($urandom_range(0, 3))
          0: pct = 10;
          1: pct = 50;
          2: pct = 90;
          default: pct = 100;
        endcase
      end
      rst            = ($urandom_range(0, 199) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom;
      id_ready       = ($urandom_range(0, 99) < pct);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fetch_stage

`default_nettype wire
